// File: rtl/demux4_rr_dist_if.sv
// demux4_rr_dist_if: stream-side and lane-side signals of the 1-to-4
// round-robin distributor. Signal names follow the distributor's own view
// (i_* flow into it, o_* flow out of it).
//   slave  : the distributor itself
//   master : the surrounding environment (upstream source + downstream lanes)
interface demux4_rr_dist_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_ready;
    logic [3:0]       o_valid;
    logic [WIDTH-1:0] o_data;
    logic [3:0]       i_ready;
    logic [1:0]       o_lane;
    logic             o_busy;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_lane, o_busy
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_lane, o_busy
    );
endinterface

// File: rtl/demux4_rr_dist.sv
// demux4_rr_dist: round-robin 1-to-4 stream distributor.
// One holding register between the input and four lanes; each word goes to
// the lane selected by a 2-bit pointer that advances 0,1,2,3,0,... after
// every lane transfer. Latency one cycle, one word per cycle sustained.
// Optional feature macro: DEMUX4_SKIP_BUSY_EN -- when the target lane is
// stalled and another lane is ready, retarget the held word to the first
// ready lane after the pointer (no transfer in that cycle).
module demux4_rr_dist #(
    parameter int WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    demux4_rr_dist_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_e;

    hold_e            state_q, state_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [WIDTH-1:0] data_q,  data_d;

    logic lane_fire;
    logic in_fire;

    // Handshake qualifiers; o_ready passes i_ready[ptr] straight through so
    // a full register can be refilled in the same cycle it drains.
    assign lane_fire   = (state_q == FULL) && bus.i_ready[ptr_q];
    assign bus.o_ready = !i_rst && ((state_q == EMPTY) || lane_fire);
    assign in_fire     = bus.i_valid && bus.o_ready;

    assign bus.o_valid = (state_q == FULL) ? (4'b0001 << ptr_q) : 4'b0000;
    assign bus.o_data  = data_q;
    assign bus.o_lane  = ptr_q;
    assign bus.o_busy  = (state_q == FULL);

`ifdef DEMUX4_SKIP_BUSY_EN
    logic [1:0] skip_lane;
    logic       skip_hit;
    logic [1:0] cand;

    // First ready lane in cyclic order after ptr; scanning the farthest
    // offset first lets the nearest hit overwrite it.
    always_comb begin
        skip_lane = ptr_q;
        skip_hit  = 1'b0;
        cand      = ptr_q;
        for (int k = 3; k >= 1; k--) begin
            cand = ptr_q + k[1:0];
            if (bus.i_ready[cand]) begin
                skip_lane = cand;
                skip_hit  = 1'b1;
            end
        end
    end
`endif

    // Next-state: pointer advance/retarget, data load, holding flag.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;

        if (lane_fire) begin
            ptr_d = ptr_q + 2'd1;
        end
`ifdef DEMUX4_SKIP_BUSY_EN
        else if ((state_q == FULL) && skip_hit) begin
            ptr_d = skip_lane;
        end
`endif

        if (in_fire) begin
            data_d  = bus.i_data;
            state_d = FULL;
        end else if (lane_fire) begin
            state_d = EMPTY;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            // NOTE: the data register is reset too, because o_data is
            // visible while empty and must read zero after reset.
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end

endmodule
